mag_comparator_pipe: RTL and testbench

Parametrised, pipelined N-bit magnitude comparator with selectable signed or unsigned mode per transaction.
- Resolves operands MSB-first, SLICE bits per pipeline stage, using the cascade rule: G = Gupper + Eupper·Glower, E = Eupper·Elower, L = Lupper + Eupper·Llower.
- Valid/ready handshake on both sides, with a tag carried alongside each transaction.
- Sits between datapath producers and threshold or ordering logic; throughput is one compare per clock.

---
 rtl/mag_cmp_pkg.sv | 33 +++
 rtl/mag_cmp_slice.sv | 19 +
 rtl/mag_comparator_pipe.sv | 121 ++++++++++++
 tb/tb_mag_comparator_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
package mag_cmp_pkg;

  // Widest slice the merge helper accepts; narrower slices are zero-extended.
  localparam int unsigned SLICE_MAX = 32;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_flags_t;

  // Flags entering the first stage: nothing resolved yet, operands "equal so far".
  localparam cmp_flags_t FLAGS_INIT = '{gt: 1'b0, eq: 1'b1};

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned slice);
    return (width + slice - 1) / slice;
  endfunction

  // Cascade rule: a lower slice only matters while the upper bits are still equal.
  function automatic cmp_flags_t merge_flags(input cmp_flags_t             prev,
                                             input logic [SLICE_MAX-1:0] a_slice,
                                             input logic [SLICE_MAX-1:0] b_slice);
    cmp_flags_t res;
    res = prev;
    if (prev.eq) begin
      res.gt = (a_slice > b_slice);
      res.eq = (a_slice == b_slice);
    end
    return res;
  endfunction

endpackage

// File: rtl/mag_cmp_slice.sv
// One pipeline stage's combinational work: compare a SLICE-bit chunk and merge
// with the flags carried from the more significant chunks.
module mag_cmp_slice
  import mag_cmp_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_slice,
  input  logic [SLICE-1:0] b_slice,
  input  cmp_flags_t       flags_in,
  output cmp_flags_t       flags_out
);

  // Merge this slice's comparison into the running flags.
  always_comb begin
    flags_out = merge_flags(flags_in, SLICE_MAX'(a_slice), SLICE_MAX'(b_slice));
  end

endmodule

// File: rtl/mag_comparator_pipe.sv
// Pipelined N-bit magnitude comparator, MSB slice first, with a global
// valid/ready advance and a pass-through tag. Latency equals STAGES.
module mag_comparator_pipe
  import mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             signed_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned STAGES = num_stages(WIDTH, SLICE);
  localparam int unsigned PW     = STAGES * SLICE;

  logic             adv;
  logic [PW-1:0]    a_in, b_in;

  // Stage registers.
  logic             vld_q [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  cmp_flags_t       flg_q [STAGES];
  logic [PW-1:0]    a_q   [STAGES];
  logic [PW-1:0]    b_q   [STAGES];
  logic             lt_q;

  // Values presented to each stage's register inputs.
  logic             vld_src [STAGES];
  logic [TAG_W-1:0] tag_src [STAGES];
  cmp_flags_t       prv_src [STAGES];
  logic [PW-1:0]    a_src   [STAGES];
  logic [PW-1:0]    b_src   [STAGES];
  cmp_flags_t       flg_d   [STAGES];

  // The last stage's operand copy has no consumer; kept for uniform stage structure.
  logic unused_ops;
  assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv;

  // Offset-binary map for signed mode, then zero-pad to a whole number of slices.
  always_comb begin
    a_in = '0;
    b_in = '0;
    a_in[WIDTH-1:0] = in1_i;
    b_in[WIDTH-1:0] = in2_i;
    if (signed_i) begin
      a_in[WIDTH-1] = ~in1_i[WIDTH-1];
      b_in[WIDTH-1] = ~in2_i[WIDTH-1];
    end
  end

  // Route the accepted transaction into stage 0 and each stage into its successor.
  always_comb begin
    vld_src[0] = in_valid_i;
    tag_src[0] = tag_i;
    prv_src[0] = FLAGS_INIT;
    a_src[0]   = a_in;
    b_src[0]   = b_in;
    for (int unsigned s = 1; s < STAGES; s++) begin
      vld_src[s] = vld_q[s-1];
      tag_src[s] = tag_q[s-1];
      prv_src[s] = flg_q[s-1];
      a_src[s]   = a_q[s-1];
      b_src[s]   = b_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    mag_cmp_slice #(.SLICE(SLICE)) u_slice (
      .a_slice   (a_src[s][(STAGES-1-s)*SLICE +: SLICE]),
      .b_slice   (b_src[s][(STAGES-1-s)*SLICE +: SLICE]),
      .flags_in  (prv_src[s]),
      .flags_out (flg_d[s])
    );
  end

  // All stages advance together; lesser is registered so reset leaves every output low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        tag_q[s] <= '0;
        flg_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
      end
      lt_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= vld_src[s];
        tag_q[s] <= tag_src[s];
        flg_q[s] <= flg_d[s];
        a_q[s]   <= a_src[s];
        b_q[s]   <= b_src[s];
      end
      lt_q <= vld_src[STAGES-1] & ~flg_d[STAGES-1].gt & ~flg_d[STAGES-1].eq;
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign greater_o   = flg_q[STAGES-1].gt;
  assign equal_o     = flg_q[STAGES-1].eq;
  assign lesser_o    = lt_q;
  assign tag_o       = tag_q[STAGES-1];

endmodule

// File: tb/tb_mag_comparator_pipe.sv
// Directed bench for mag_comparator_pipe: a 16/4 instance (4 stages) and a
// 10/4 instance (3 stages). Inputs change and outputs are sampled on negedge.
module tb_mag_comparator_pipe;

  localparam logic [2:0] RG = 3'b100;
  localparam logic [2:0] RE = 3'b010;
  localparam logic [2:0] RL = 3'b001;

  logic clk = 1'b0;
  logic rst_n;

  logic        w_in_valid, w_in_ready, w_signed, w_out_valid, w_out_ready;
  logic [15:0] w_in1, w_in2;
  logic [3:0]  w_tag_in, w_tag_out;
  logic        w_gt, w_eq, w_lt;

  logic        n_in_valid, n_in_ready, n_signed, n_out_valid, n_out_ready;
  logic [9:0]  n_in1, n_in2;
  logic [3:0]  n_tag_in, n_tag_out;
  logic        n_gt, n_eq, n_lt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mag_comparator_pipe #(.WIDTH(16), .SLICE(4), .TAG_W(4)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .in1_i(w_in1), .in2_i(w_in2), .signed_i(w_signed), .tag_i(w_tag_in),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
    .greater_o(w_gt), .equal_o(w_eq), .lesser_o(w_lt), .tag_o(w_tag_out)
  );

  mag_comparator_pipe #(.WIDTH(10), .SLICE(4), .TAG_W(4)) dut_n (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
    .in1_i(n_in1), .in2_i(n_in2), .signed_i(n_signed), .tag_i(n_tag_in),
    .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
    .greater_o(n_gt), .equal_o(n_eq), .lesser_o(n_lt), .tag_o(n_tag_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_w(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sg, input logic [3:0] tg);
    w_in_valid = v; w_in1 = a; w_in2 = b; w_signed = sg; w_tag_in = tg;
  endtask

  // Single transaction through either instance, checking exact latency.
  task automatic run_one(input string name, input bit narrow,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic sg, input logic [3:0] tg, input logic [2:0] res);
    int unsigned lat;
    lat = narrow ? 3 : 4;
    @(negedge clk);
    if (narrow) begin
      n_in_valid = 1'b1; n_in1 = a[9:0]; n_in2 = b[9:0]; n_signed = sg; n_tag_in = tg;
    end else begin
      drive_w(1'b1, a, b, sg, tg);
    end
    @(negedge clk);
    n_in_valid = 1'b0;
    w_in_valid = 1'b0;
    repeat (lat - 2) @(negedge clk);
    check({name, "/early"}, narrow ? n_out_valid : w_out_valid, 0);
    @(negedge clk);
    check({name, "/valid"}, narrow ? n_out_valid : w_out_valid, 1);
    check({name, "/res"}, narrow ? {n_gt, n_eq, n_lt} : {w_gt, w_eq, w_lt}, res);
    check({name, "/tag"}, narrow ? n_tag_out : w_tag_out, tg);
  endtask

  logic [15:0] bb_a   [8] = '{16'h0000, 16'hABCD, 16'h0F00, 16'h8000, 16'h8000, 16'hFFFE, 16'h1234, 16'h0001};
  logic [15:0] bb_b   [8] = '{16'h0000, 16'hABCC, 16'h1000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h1234, 16'hFFFF};
  logic        bb_s   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0]  bb_r   [8] = '{RE, RG, RL, RL, RG, RL, RE, RG};

  logic [15:0] st_a   [5] = '{16'h0010, 16'h9000, 16'h9000, 16'h5555, 16'h0100};
  logic [15:0] st_b   [5] = '{16'h0020, 16'h1000, 16'h1000, 16'h5555, 16'h00FF};
  logic        st_s   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  st_r   [5] = '{RL, RL, RG, RE, RG};
  // Per negedge k of the stall test: expected output valid, index of result, in_ready.
  logic        st_ev  [12] = '{0,0,0,0, 1,1,1, 1,1,1,1, 0};
  int          st_ei  [12] = '{0,0,0,0, 0,0,0, 1,2,3,4, 0};
  logic        st_er  [12] = '{1,1,1,1, 0,0,0, 1,1,1,1, 1};

  initial begin
    rst_n = 1'b0;
    drive_w(1'b0, '0, '0, 1'b0, '0);
    w_out_ready = 1'b1;
    n_in_valid = 1'b0; n_in1 = '0; n_in2 = '0; n_signed = 1'b0; n_tag_in = '0;
    n_out_ready = 1'b1;

    #13;
    check("rst/valid", w_out_valid, 0);
    check("rst/flags", {w_gt, w_eq, w_lt}, 3'b000);
    check("rst/tag", w_tag_out, 0);
    check("rst/n_flags", {n_out_valid, n_gt, n_eq, n_lt}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready", w_in_ready, 1);

    // Basic and signed/unsigned single transactions.
    run_one("t1",        1'b0, 16'h1234, 16'h1235, 1'b0, 4'h3, RL);
    run_one("t2_s",      1'b0, 16'h8000, 16'h0001, 1'b1, 4'h4, RL);
    run_one("t2_u",      1'b0, 16'h8000, 16'h0001, 1'b0, 4'h5, RG);
    run_one("t2_eq_s",   1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 4'h6, RE);
    run_one("t2_eq_u",   1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 4'h7, RE);
    run_one("t2_zero_m1",1'b0, 16'h0000, 16'hFFFF, 1'b1, 4'h8, RG);
    run_one("t2_max_min",1'b0, 16'h7FFF, 16'h8000, 1'b1, 4'h9, RG);
    run_one("t2_lsb",    1'b0, 16'hF0F1, 16'hF0F0, 1'b0, 4'hA, RG);

    // Back-to-back stream, out_ready held high.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("bb/ready", w_in_ready, 1);
        if (k >= 4 && k <= 11) begin
          check("bb/valid", w_out_valid, 1);
          check("bb/tag", w_tag_out, k - 4);
          check("bb/res", {w_gt, w_eq, w_lt}, bb_r[k-4]);
        end else begin
          check("bb/idle", w_out_valid, 0);
        end
      end
      if (k < 8) drive_w(1'b1, bb_a[k], bb_b[k], bb_s[k], 4'(k));
      else       w_in_valid = 1'b0;
    end

    // Fill with consumer stalled, offer a fifth while full, then release.
    w_out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("st/ready", w_in_ready, st_er[k]);
      check("st/valid", w_out_valid, st_ev[k]);
      if (st_ev[k]) begin
        check("st/tag", w_tag_out, 8 + st_ei[k]);
        check("st/res", {w_gt, w_eq, w_lt}, st_r[st_ei[k]]);
      end
      if (k < 4)      drive_w(1'b1, st_a[k], st_b[k], st_s[k], 4'(8 + k));
      else if (k < 7) drive_w(1'b1, st_a[4], st_b[4], st_s[4], 4'hC);
      else            w_in_valid = 1'b0;
      if (k == 6) w_out_ready = 1'b1;
    end

    // Narrow instance with a partial top slice.
    run_one("t5_u",   1'b1, 16'h03FF, 16'h03FE, 1'b0, 4'h1, RG);
    run_one("t5_s",   1'b1, 16'h0200, 16'h01FF, 1'b1, 4'h2, RL);
    run_one("t5_u2",  1'b1, 16'h0200, 16'h01FF, 1'b0, 4'h3, RG);
    run_one("t5_m1",  1'b1, 16'h03FF, 16'h0000, 1'b1, 4'h4, RL);

    // Asynchronous reset with transactions in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_w(1'b1, 16'h4000 + 16'(k), 16'h4000, 1'b0, 4'(k + 1));
    end
    @(negedge clk);
    w_in_valid = 1'b0;
    check("ar/pre_valid", w_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar/valid", w_out_valid, 0);
    check("ar/outs", {w_gt, w_eq, w_lt, w_tag_out}, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ar/no_stale", w_out_valid, 0);
      check("ar/ready", w_in_ready, 1);
    end
    run_one("ar/after", 1'b0, 16'h0002, 16'h0003, 1'b0, 4'hE, RL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
